// File: rtl/shift_mult_pkg.sv
// Shared types and helpers for the shift-and-add multiplier sequencer.
package shift_mult_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} seq_state_t;

    // Step-counter width for a given word length; never narrower than one bit.
    function automatic int cnt_width(input int word_length);
        return (word_length <= 2) ? 1 : $clog2(word_length);
    endfunction

endpackage

// File: rtl/shift_mult_sequencer_if.sv
// Control bundle between the sequencer and the multiplier datapath.
// master = datapath side (supplies status, consumes enables),
// slave  = sequencer side.
interface shift_mult_sequencer_if #(
    parameter int CNT_W = 3
);
    logic             start;
    logic             multiplier_lsb;
    logic             multiplier_zero;
    logic             load_en;
    logic             shift_en;
    logic             acc_en;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] step_count;

    modport master (
        output start, multiplier_lsb, multiplier_zero,
        input  load_en, shift_en, acc_en, busy, done, step_count
    );

    modport slave (
        input  start, multiplier_lsb, multiplier_zero,
        output load_en, shift_en, acc_en, busy, done, step_count
    );
endinterface

// File: rtl/shift_mult_sequencer_step_counter.sv
// Sync-clear, enable-gated up-counter that tracks the current RUN step.
module step_counter
    import shift_mult_pkg::*;
#(
    parameter int Word_Length = 8,
    parameter int CNT_W       = cnt_width(Word_Length)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             term_cnt
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(Word_Length - 1);

    logic [CNT_W-1:0] count_reg;

    // Clear has priority over counting so the last step never wraps.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign count    = count_reg;
    assign term_cnt = (count_reg == LAST_STEP);

endmodule

// File: rtl/shift_mult_sequencer.sv
// Control FSM for a shift-and-add multiplier: load, Word_Length shift/accumulate
// steps (or fewer with early exit on a zero multiplier), then a done pulse.
module shift_mult_sequencer
    import shift_mult_pkg::*;
#(
    parameter int Word_Length = 8,
    parameter bit EARLY_EXIT  = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    shift_mult_sequencer_if.slave  bus
);

    localparam int CNT_W = cnt_width(Word_Length);

    seq_state_t       state_reg;
    logic             load_reg;
    logic             run_reg;
    logic             busy_reg;
    logic             done_reg;

    logic             early_stop;
    logic             run_exit;
    logic             term_cnt;
    logic             cnt_clr;
    logic [CNT_W-1:0] count;

    // A zero multiplier ends RUN without spending a shift on it.
    assign early_stop = EARLY_EXIT && bus.multiplier_zero;
    assign run_exit   = run_reg && (term_cnt || early_stop);

    // Counter sits at zero everywhere except RUN, and is reset on leaving RUN.
    assign cnt_clr    = !run_reg || run_exit;

    step_counter #(
        .Word_Length (Word_Length),
        .CNT_W       (CNT_W)
    ) u_step_counter (
        .clk      (clk),
        .reset    (reset),
        .clr      (cnt_clr),
        .en       (run_reg),
        .count    (count),
        .term_cnt (term_cnt)
    );

    // State register with the state-decoded outputs registered alongside it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            load_reg  <= 1'b0;
            run_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            load_reg <= 1'b0;
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        state_reg <= LOAD;
                        load_reg  <= 1'b1;
                        busy_reg  <= 1'b1;
                    end
                end
                LOAD: begin
                    state_reg <= RUN;
                    run_reg   <= 1'b1;
                    busy_reg  <= 1'b1;
                end
                RUN: begin
                    if (run_exit) begin
                        state_reg <= DONE;
                        run_reg   <= 1'b0;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    run_reg   <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.load_en    = load_reg;
    assign bus.shift_en   = run_reg && !early_stop;
    assign bus.acc_en     = run_reg && !early_stop && bus.multiplier_lsb;
    assign bus.busy       = busy_reg;
    assign bus.done       = done_reg;
    assign bus.step_count = count;

endmodule
